systolic_array_feed_ctrl: RTL

- Sequences one N x N systolic-array accumulation pass for the LK matrix build (e.g. A^T A over a window).
- Accepts a job command, clears the PE accumulators, then streams K operand vectors into the array's west edge.
- Skews each lane by its row index, flushes the array with zeros, and signals completion.
- Sits between the window-gather stage and the systolic_array PE grid.

---
 rtl/systolic_array_pkg.sv | 24 ++
 rtl/systolic_array_SkewBuffer.sv | 51 +++++
 rtl/systolic_array_feed_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/systolic_array_pkg.sv
// Shared types and constants for the systolic-array feed controller and its skew buffer.
package systolic_array_pkg;

    localparam int unsigned SA_N      = 4;
    localparam int unsigned SA_DATA_W = 32;
    localparam int unsigned SA_LEN_W  = 8;
    localparam int unsigned SA_DRAIN  = 8;

    localparam int unsigned ST_W = 3;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_FEED  = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Lane i of a packed operand vector starts at bit i*width.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_array_SkewBuffer.sv
// Per-lane delay lines: lane i is delayed by 1+i register stages so the array sees a diagonal wavefront.
module systolic_array_SkewBuffer
    import systolic_array_pkg::*;
#(
    parameter int unsigned N  = SA_N,
    parameter int unsigned DW = SA_DATA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_shift,
    input  logic            i_zero,
    input  logic [N*DW-1:0] i_data,
    output logic [N*DW-1:0] o_data
);

    for (genvar g = 0; g < N; g++) begin : g_lane
        localparam int unsigned LSB   = lane_lsb(g, DW);
        localparam int unsigned DEPTH = g + 1;

        logic [DEPTH*DW-1:0] r_dly;
        logic [DW-1:0]       w_lane_in;

        assign w_lane_in = i_data[LSB +: DW];

        // Newest sample sits in the low slice; the oldest (top) slice drives the lane.
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dly <= '0;
                end else if (i_zero) begin
                    r_dly <= '0;
                end else if (i_shift) begin
                    r_dly <= w_lane_in;
                end
            end
        end else begin : g_many
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dly <= '0;
                end else if (i_zero) begin
                    r_dly <= '0;
                end else if (i_shift) begin
                    r_dly <= {r_dly[(DEPTH-1)*DW-1:0], w_lane_in};
                end
            end
        end

        assign o_data[LSB +: DW] = r_dly[DEPTH*DW-1 -: DW];
    end

endmodule

// File: rtl/systolic_array_feed_ctrl.sv
// Sequences one accumulation pass: clear the PEs, stream K skewed operand vectors, flush with zeros, report done.
module systolic_array_feed_ctrl
    import systolic_array_pkg::*;
#(
    parameter int unsigned N            = SA_N,
    parameter int unsigned data_width   = SA_DATA_W,
    parameter int unsigned len_width    = SA_LEN_W,
    parameter int unsigned drain_cycles = SA_DRAIN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_val,
    output logic                    req_rdy,
    input  logic [len_width-1:0]    req_len,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [N*data_width-1:0] in_data,
    output logic [N*data_width-1:0] x_feed,
    output logic                    pe_clear,
    output logic                    busy,
    output logic                    resp_val,
    input  logic                    resp_rdy
);

    localparam logic [len_width-1:0] DRAIN_LOAD = len_width'(drain_cycles - 1);
    localparam logic [len_width-1:0] ONE        = len_width'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [len_width-1:0]    r_len;
    logic [len_width-1:0]    r_beat_cnt;
    logic [len_width-1:0]    r_drain_cnt;
    logic [len_width-1:0]    w_beat_inc;
    logic                    w_beat_acc;
    logic                    w_enter_drain;
    logic [N*data_width-1:0] w_skew_in;

    assign w_beat_inc = r_beat_cnt + ONE;
    assign w_beat_acc = (r_state == ST_FEED) && in_val;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (req_val)                     w_state_nxt = ST_CLEAR;
            ST_CLEAR: w_state_nxt = (r_len != '0) ? ST_FEED : ST_DRAIN;
            ST_FEED:  if (w_beat_acc && (w_beat_inc == r_len)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt == '0)           w_state_nxt = ST_DONE;
            ST_DONE:  if (resp_rdy)                    w_state_nxt = ST_IDLE;
            default:                                   w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_enter_drain = (w_state_nxt == ST_DRAIN) && (r_state != ST_DRAIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && req_val) begin
                r_len      <= req_len;
                r_beat_cnt <= '0;
            end
            if (w_beat_acc) begin
                r_beat_cnt <= w_beat_inc;
            end
            if (w_enter_drain) begin
                r_drain_cnt <= DRAIN_LOAD;
            end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
                r_drain_cnt <= r_drain_cnt - ONE;
            end
        end
    end

    // Moore outputs: decoded from the state register only.
    assign req_rdy  = (r_state == ST_IDLE);
    assign in_rdy   = (r_state == ST_FEED);
    assign pe_clear = (r_state == ST_CLEAR);
    assign busy     = (r_state != ST_IDLE);
    assign resp_val = (r_state == ST_DONE);

    // A missing beat in FEED becomes a zero bubble so the array never stalls.
    assign w_skew_in = w_beat_acc ? in_data : '0;

    systolic_array_SkewBuffer #(
        .N  (N),
        .DW (data_width)
    ) u_skew (
        .clk     (clk),
        .rst_n   (reset),
        .i_shift (r_state != ST_IDLE),
        .i_zero  (w_state_nxt == ST_IDLE),
        .i_data  (w_skew_in),
        .o_data  (x_feed)
    );

endmodule
